// File: rtl/addf_share_arbiter.sv
// Shares one pipelined FP adder between two requesters, tagging each issue so results route back in order.
// Optional macro ADDF_SHARE_RR_EN selects round-robin tie breaking; default is fixed priority to requester 0.
module addf_share_arbiter #(
   parameter int DATA_TYPE = 32,
   parameter int LATENCY   = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] in0_lhs,
   input  logic [DATA_TYPE-1:0] in0_rhs,
   input  logic                 in0_valid,
   output logic                 in0_ready,
   input  logic [DATA_TYPE-1:0] in1_lhs,
   input  logic [DATA_TYPE-1:0] in1_rhs,
   input  logic                 in1_valid,
   output logic                 in1_ready,
   output logic [DATA_TYPE-1:0] out0_result,
   output logic                 out0_valid,
   input  logic                 out0_ready,
   output logic [DATA_TYPE-1:0] out1_result,
   output logic                 out1_valid,
   input  logic                 out1_ready,
   output logic [DATA_TYPE-1:0] unit_lhs,
   output logic [DATA_TYPE-1:0] unit_rhs,
   output logic                 unit_ce,
   input  logic [DATA_TYPE-1:0] unit_result
);

   logic [LATENCY-1:0]   vld_q, vld_d, id_q, id_d;
   logic [DATA_TYPE-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
   logic                 tail_vld, tail_id, grant, gnt1;

   assign tail_vld = vld_q[LATENCY-1];
   assign tail_id  = id_q[LATENCY-1];

`ifdef ADDF_SHARE_RR_EN
   // last_q holds the id granted most recently; reset value 1 lets requester 0 win the first tie
   logic last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (grant) last_d = gnt1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= 1'b1;
      else      last_q <= last_d;
   end

   assign gnt1 = in1_valid & (~in0_valid | ~last_q);
`else
   assign gnt1 = in1_valid & ~in0_valid;
`endif

   always_comb begin
      unit_ce   = ~(tail_vld & (tail_id ? ~out1_ready : ~out0_ready));
      // rst gates the grant so no requester sees ready while reset is held
      grant     = rst & unit_ce & (in0_valid | in1_valid);
      in0_ready = grant & ~gnt1;
      in1_ready = grant & gnt1;
   end

   always_comb begin
      vld_d = vld_q;
      id_d  = id_q;
      if (unit_ce) begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
         end
         vld_d[0] = grant;
         id_d[0]  = gnt1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         vld_q <= vld_d;
         id_q  <= id_d;
      end
   end

   // Operands pass straight through in the grant cycle and are held afterwards
   always_comb begin
      lhs_d = lhs_q;
      rhs_d = rhs_q;
      if (grant) begin
         lhs_d = gnt1 ? in1_lhs : in0_lhs;
         rhs_d = gnt1 ? in1_rhs : in0_rhs;
      end
   end

   always_ff @(posedge clk) begin
      lhs_q <= lhs_d;
      rhs_q <= rhs_d;
   end

   assign unit_lhs    = lhs_d;
   assign unit_rhs    = rhs_d;
   assign out0_valid  = tail_vld & ~tail_id;
   assign out1_valid  = tail_vld & tail_id;
   assign out0_result = unit_result;
   assign out1_result = unit_result;

endmodule

// File: tb/tb_addf_share_arbiter.sv
// Directed bench for addf_share_arbiter with a behavioural ce-gated FP adder pipeline as the shared core.
module tb_addf_share_arbiter;
   localparam int L = 9;

   logic        clk, rst;
   logic [31:0] in0_lhs, in0_rhs, in1_lhs, in1_rhs;
   logic        in0_valid, in0_ready, in1_valid, in1_ready;
   logic [31:0] out0_result, out1_result, unit_lhs, unit_rhs, unit_result;
   logic        out0_valid, out0_ready, out1_valid, out1_ready, unit_ce;

   int n_chk = 0, n_bad = 0;

   addf_share_arbiter #(.DATA_TYPE(32), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .in0_lhs(in0_lhs), .in0_rhs(in0_rhs), .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in1_lhs(in1_lhs), .in1_rhs(in1_rhs), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .out0_result(out0_result), .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out1_result(out1_result), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .unit_lhs(unit_lhs), .unit_rhs(unit_rhs), .unit_ce(unit_ce), .unit_result(unit_result)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Normal-number fp32 <-> real conversion for the core model
   function automatic real f2r(input logic [31:0] b);
      logic [10:0] e;
      if (b[30:0] == 31'd0) return 0.0;
      e = 11'(b[30:23]) + 11'd896;
      return $bitstoreal({b[31], e, b[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   logic [31:0] pipe [L];
   always @(posedge clk)
      if (unit_ce) begin
         for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= r2f(f2r(unit_lhs) + f2r(unit_rhs));
      end
   assign unit_result = pipe[L-1];

   typedef struct packed { logic id; logic [31:0] res; } rec_t;
   rec_t rq[$];
   logic gid[$];

   always @(posedge clk)
      if (rst) begin
         if (in0_valid && in0_ready) gid.push_back(1'b0);
         if (in1_valid && in1_ready) gid.push_back(1'b1);
         if (out0_valid && out0_ready) rq.push_back({1'b0, out0_result});
         if (out1_valid && out1_ready) rq.push_back({1'b1, out1_result});
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   localparam logic [31:0] F0_5 = 32'h3f000000, F1 = 32'h3f800000, F2 = 32'h40000000,
                           F3 = 32'h40400000, F4 = 32'h40800000, F1_5 = 32'h3fc00000;
   logic [31:0] b2b_lhs [8] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
   logic [31:0] b2b_res [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
                                32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};

   initial begin
      int          lat, nt, sent;
      logic        seen1, seen_any, acc;
      logic [31:0] res;
      logic        exp_id [5];

      // reset state, with a requester already valid
      rst = 0; in0_valid = 1; in1_valid = 1; out0_ready = 1; out1_ready = 1;
      in0_lhs = F1; in0_rhs = F1; in1_lhs = F2; in1_rhs = F2;
      wait_cyc(3);
      chk("rst_out0_valid", 32'(out0_valid), 0);
      chk("rst_out1_valid", 32'(out1_valid), 0);
      chk("rst_in0_ready", 32'(in0_ready), 0);
      chk("rst_in1_ready", 32'(in1_ready), 0);
      chk("rst_unit_ce", 32'(unit_ce), 1);

      // tie between both requesters
`ifdef ADDF_SHARE_RR_EN
      nt = 4; exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
      nt = 5; exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      rst = 1;
      wait_cyc(nt);
      in0_valid = 0; in1_valid = 0;
      wait_cyc(L + 3);
      chk("tie_grant_cnt", 32'(gid.size()), 32'(nt));
      chk("tie_res_cnt", 32'(rq.size()), 32'(nt));
      for (int k = 0; k < nt && k < gid.size() && k < rq.size(); k++) begin
         chk($sformatf("tie_grant%0d", k), 32'(gid[k]), 32'(exp_id[k]));
         chk($sformatf("tie_res_id%0d", k), 32'(rq[k].id), 32'(exp_id[k]));
         chk($sformatf("tie_res%0d", k), rq[k].res, exp_id[k] ? F4 : F2);
      end
      rq.delete(); gid.delete();

      // single issue 1.0 + 2.0 from requester 0
      in0_lhs = F1; in0_rhs = F2; in0_valid = 1;
      #1;
      chk("single_ready", 32'(in0_ready), 1);
      chk("single_unit_lhs", unit_lhs, F1);
      chk("single_unit_rhs", unit_rhs, F2);
      tick();
      in0_valid = 0; in0_lhs = F4; in0_rhs = F4;
      lat = -1; seen1 = 0; res = 0;
      for (int c = 1; c <= L + 4; c++) begin
         if (c == 1) chk("single_hold_lhs", unit_lhs, F1);
         if (out1_valid) seen1 = 1;
         if (out0_valid && lat < 0) begin lat = c; res = out0_result; end
         tick();
      end
      chk("single_latency", 32'(lat), 32'(L));
      chk("single_result", res, F3);
      chk("single_out1_quiet", 32'(seen1), 0);
      chk("single_once", 32'(rq.size()), 1);
      rq.delete(); gid.delete();

      // stall with requester-1 result at the tail
      out1_ready = 0; in1_lhs = F1; in1_rhs = F0_5; in1_valid = 1;
      tick();
      in1_valid = 0;
      seen_any = 0;
      for (int c = 0; c < L + 4; c++) begin
         if (out1_valid) begin seen_any = 1; break; end
         tick();
      end
      chk("stall_reach_tail", 32'(seen_any), 1);
      in0_valid = 1; in1_valid = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_unit_ce", 32'(unit_ce), 0);
         chk("stall_in0_ready", 32'(in0_ready), 0);
         chk("stall_in1_ready", 32'(in1_ready), 0);
         chk("stall_out1_valid", 32'(out1_valid), 1);
         chk("stall_result", out1_result, F1_5);
         tick();
      end
      in0_valid = 0; in1_valid = 0; out1_ready = 1;
      #1;
      chk("stall_release_ce", 32'(unit_ce), 1);
      tick();
      chk("stall_delivered", 32'(rq.size()), 1);
      if (rq.size() > 0) chk("stall_deliv_res", rq[0].res, F1_5);
      wait_cyc(2);
      chk("stall_no_dup", 32'(rq.size()), 1);
      rq.delete(); gid.delete();

      // requester 0 streams 8 ops while out0_ready toggles
      sent = 0; in1_valid = 0;
      for (int c = 0; c < 200 && (sent < 8 || rq.size() < 8); c++) begin
         out0_ready = c[0];
         in0_valid = (sent < 8);
         if (sent < 8) begin in0_lhs = b2b_lhs[sent]; in0_rhs = F1; end
         #1;
         acc = in0_valid & in0_ready;
         tick();
         if (acc) sent++;
      end
      in0_valid = 0; out0_ready = 1;
      wait_cyc(L + 3);
      chk("b2b_sent", 32'(sent), 8);
      chk("b2b_count", 32'(rq.size()), 8);
      for (int k = 0; k < 8 && k < rq.size(); k++) begin
         chk($sformatf("b2b_res%0d", k), rq[k].res, b2b_res[k]);
         chk($sformatf("b2b_id%0d", k), 32'(rq[k].id), 0);
      end
      rq.delete(); gid.delete();

      // reset asserted with three issues in flight
      in0_lhs = F1; in0_rhs = F1; in0_valid = 1;
      wait_cyc(3);
      in0_valid = 0;
      tick();
      rst = 0;
      wait_cyc(2);
      rst = 1;
      seen_any = 0;
      for (int c = 0; c < L + 4; c++) begin
         if (out0_valid || out1_valid) seen_any = 1;
         tick();
      end
      chk("rstmid_no_valid", 32'(seen_any), 0);
      chk("rstmid_no_result", 32'(rq.size()), 0);
      in0_valid = 1; in1_valid = 1;
      #1;
      chk("rstmid_first_in0", 32'(in0_ready), 1);
      chk("rstmid_first_in1", 32'(in1_ready), 0);
      tick();
      in0_valid = 0; in1_valid = 0;
      wait_cyc(L + 3);
      chk("rstmid_new_count", 32'(rq.size()), 1);
      if (rq.size() > 0) begin
         chk("rstmid_new_id", 32'(rq[0].id), 0);
         chk("rstmid_new_res", rq[0].res, F2);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/addf_share_arbiter.md
ADDF_SHARE_ARBITER -- requirements
Module: addf_share_arbiter

Interface
REQ-001 Parameter: DATA_TYPE, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter: LATENCY, default 9, pipeline depth in ce-enabled cycles of the shared adder core; legal range 1..32.
REQ-003 Port: clk  in  1  single clock; all state on the rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Ports: in0_lhs, in0_rhs  in  DATA_TYPE each  requester-0 operands.
REQ-006 Ports: in0_valid  in  1 / in0_ready  out  1  requester-0 joined handshake; covers both operands.
REQ-007 Ports: in1_lhs, in1_rhs, in1_valid, in1_ready  requester 1, identical to requester 0.
REQ-008 Ports: out0_result  out  DATA_TYPE / out0_valid  out  1 / out0_ready  in  1  requester-0 result channel.
REQ-009 Ports: out1_result, out1_valid, out1_ready  requester-1 result channel, identical to out0.
REQ-010 Ports: unit_lhs, unit_rhs  out  DATA_TYPE / unit_ce  out  1 / unit_result  in  DATA_TYPE  connection to the shared adder core.

Function
REQ-011 Tag pipeline: LATENCY stages, each holding {valid, id}, SHALL advance one stage exactly when unit_ce=1.
REQ-012 stall = tail.valid AND NOT outN_ready, where N = tail.id; unit_ce = NOT stall (combinational).
REQ-013 Grant SHALL occur only when unit_ce=1; at most one requester granted per cycle; inX_ready=1 only for the granted requester.
REQ-014 Granted operands SHALL drive unit_lhs/unit_rhs in the grant cycle; with no grant they hold the last granted values.
REQ-015 Stage 0 SHALL load {1, granted id} on a grant, and {0, x} when unit_ce=1 with no grant.
REQ-016 outN_valid = tail.valid AND (tail.id = N); out0_result = out1_result = unit_result.
REQ-017 Latency: operands accepted at edge t SHALL appear on the result channel in the cycle following edge t+LATENCY-1 when no stall occurs; each stall cycle adds one cycle.
REQ-018 Throughput: one issue per cycle while no stall is present; results SHALL return in issue order.
REQ-019 Stall: the tail holds, all stages freeze, both inX_ready=0, and the arbitration pointer is unchanged.
REQ-020 Simultaneous tail handshake and new grant in the same cycle SHALL both complete (pipeline shifts).
REQ-021 Only one requester valid: that requester is granted regardless of the pointer.
REQ-022 Valids SHALL NOT depend on readies; ready depends on valid, arbitration state and out readies only.

Reset
REQ-023 While rst=0: all tag valids=0, out0_valid=out1_valid=0, in0_ready=in1_ready=0, unit_ce=1, pointer=last-granted-1 (requester 0 wins first tie).
REQ-024 Reset asserted mid-operation SHALL discard in-flight tags; results for them SHALL never be presented.
REQ-025 Operand registers, if any, need no reset value.

Configuration
REQ-026 Macro ADDF_SHARE_RR_EN defined: round-robin; on a tie the grant goes to the requester not granted last; the pointer updates on every grant.
REQ-027 Macro ADDF_SHARE_RR_EN undefined: fixed priority, requester 0 always wins ties; the pointer logic is absent.

Verification
REQ-028 Single issue: in0 1.0+2.0 at cycle 0, outs ready -> out0_valid with 0x40400000 at cycle LATENCY, out1_valid never 1.
REQ-029 Tie under RR: both valid for 4 cycles -> grants 0,1,0,1; results return in the same order on out0/out1.
REQ-030 Stall: tail id=1, out1_ready=0 for 3 cycles -> unit_ce=0 and in0_ready=in1_ready=0 for 3 cycles; result held stable, then delivered.
REQ-031 Fixed priority (macro undefined): both valid for 5 cycles -> 5 grants to requester 0, none to requester 1.
REQ-032 Reset mid-flight: 3 issues, rst=0 at cycle 4 for 2 cycles -> no outN_valid until new issues; first new grant goes to requester 0.
REQ-033 Back-to-back with drain: out0_ready toggling 1/0 while in0 streams 8 ops -> all 8 results delivered once each, in order, none lost or duplicated.
